param_updown_counter: RTL and testbench
=======================================

Name: param_updown_counter

Overview:
- Parametrised up/down counter for the board-level counter designs: N hex or BCD digits, programmable terminal value, synchronous load and clear, wrap or saturate mode.
- Feeds per-digit hexdisp instances; count[4k+3:4k] drives digit k.
- Replaces the fixed 16-bit enable/reset counter; adds direction, load, limit, BCD mode and terminal-count/overflow flags.

Parameters:
- DIGITS, 4, number of 4-bit digits; W = 4*DIGITS.
- BCD, 0, 0 = binary counting over W bits; 1 = each digit counts 0-9 with decimal carry/borrow.
- SATURATE, 0, 0 = wrap at boundaries; 1 = hold at boundary.

Ports:
- clock  input  1  rising-edge clock.
- resetN  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear.
- en  input  1  count enable.
- up  input  1  1 = increment, 0 = decrement; sampled only when en=1.
- load  input  1  synchronous load of load_val.
- load_val  input  W  value to load.
- limit  input  W  terminal value; count range is 0..limit.
- count  output  W  registered count.
- tc  output  1  registered one-cycle pulse on a boundary event.
- ovf  output  1  sticky boundary flag.

Behaviour:
- Reset (resetN=0, asynchronous): count=0, tc=0, ovf=0, independent of clock.
- All other updates occur on the rising clock edge. Priority is clr > load > en.
- clr=1: count=0, tc=0, ovf=0.
- load=1 (clr=0): count=min(load_val, limit); tc=0; ovf unchanged; en ignored.
- en=1, up=1:
  - If count < limit: count+1.
  - If count >= limit: boundary event. SATURATE=0 gives 0; SATURATE=1 gives limit.
- en=1, up=0:
  - If count == 0: boundary event. SATURATE=0 gives limit; SATURATE=1 gives 0.
  - If count > limit: count=limit (not a boundary event).
  - Otherwise: count-1.
- en=0 (clr=0, load=0): count holds.
- Boundary event: tc=1 for exactly the cycle after that edge, then 0 unless another event occurs. ovf is set to 1 and stays set until clr or reset.
- Any edge with no boundary event: tc=0.
- Comparisons are unsigned on the full W-bit value. In BCD mode, digits are compared most-significant first, which equals decimal compare.
- BCD=1 arithmetic:
  - Increment: a digit at 9 becomes 0 and carries to the next digit.
  - Decrement: a digit at 0 becomes 9 and borrows from the next digit.
  - Digits of load_val and limit above 9 are clamped to 9 before use.
  - count never holds a digit above 9.
- BCD=0: plain W-bit binary. limit = all ones gives full-range modulo-2^W counting.
- limit changed mid-count below the current count: the next up-count is a boundary event; the next down-count gives count=limit.
- limit = 0: count stays 0. Every enabled step is a boundary event, so tc pulses each enabled cycle.
- Reset asserted mid-count clears count, tc and ovf immediately. The first edge after resetN rises applies normal rules.

Test Plan:
- DIGITS=2, BCD=0, SATURATE=0, limit=8'h05, en=1, up=1 for 7 edges from reset → count 1,2,3,4,5,0,1; tc high only after the 6th edge; ovf=1 afterwards.
- DIGITS=2, BCD=1, limit=8'h99, load_val=8'h09, load then up 2 edges → 09, 10, 11. Down from 00 with SATURATE=0 → 99, tc=1.
- SATURATE=1, DIGITS=1, limit=4'hA, count at A, up 3 edges → stays A, tc high each cycle. Down from 0 → holds 0, tc=1.
- clr, load and en all high together, count=3 → count=0, ovf=0. Then load=1 with load_val=4'hF, limit=4'h7 → count=7.
- BCD=1, DIGITS=2, load_val=8'h3C → count=39. limit dropped to 8'h20 with count=39 and up → count=00, tc=1. Same case with down → count=20, tc=0.
- resetN pulsed low mid-clock-period while counting at 8'h42 → count=0, tc=0, ovf=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/param_updown_counter.sv
// -----------------------------------------------------------------------------
// param_updown_counter
//   Up/down counter of DIGITS 4-bit digits (W = 4*DIGITS bits). It counts in
//   plain binary or per-digit BCD, over the range 0..limit. In wrap mode it
//   rolls over at either end of the range; in saturate mode it holds there.
//   count[4k+3:4k] drives display digit k.
//
// Ports
//   clock     in   rising-edge clock
//   resetN    in   asynchronous active-low reset (clears count, tc, ovf)
//   clr       in   synchronous clear (highest priority)
//   en        in   count enable
//   up        in   1 = increment, 0 = decrement (used only when en=1)
//   load      in   synchronous load of min(load_val, limit)
//   load_val  in   W-bit value to load
//   limit     in   W-bit terminal value
//   count     out  registered count
//   tc        out  one-cycle pulse after an edge that hit a boundary
//   ovf       out  sticky boundary flag, cleared only by clr or reset
// -----------------------------------------------------------------------------
module param_updown_counter #(
  parameter int DIGITS   = 4,
  parameter int BCD      = 0,
  parameter int SATURATE = 0
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   limit,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  ovf
);

  localparam int W = 4 * DIGITS;

  // In BCD mode any digit above 9 is treated as 9; binary values pass through.
  function automatic logic [W-1:0] clamp_digits(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    if (BCD != 0) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (v[4*k +: 4] > 4'd9) r[4*k +: 4] = 4'd9;
      end
    end
    return r;
  endfunction

  // Increment: binary add, or ripple a decimal carry from the low digit up.
  function automatic logic [W-1:0] step_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    if (BCD == 0) begin
      r = v + W'(1);
    end else begin
      for (int k = 0; k < DIGITS; k++) begin
        if (carry) begin
          if (r[4*k +: 4] == 4'd9) begin
            r[4*k +: 4] = 4'd0;
          end else begin
            r[4*k +: 4] = r[4*k +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Decrement: binary subtract, or ripple a decimal borrow from the low digit up.
  function automatic logic [W-1:0] step_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    if (BCD == 0) begin
      r = v - W'(1);
    end else begin
      for (int k = 0; k < DIGITS; k++) begin
        if (borrow) begin
          if (r[4*k +: 4] == 4'd0) begin
            r[4*k +: 4] = 4'd9;
          end else begin
            r[4*k +: 4] = r[4*k +: 4] - 4'd1;
            borrow      = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  logic [W-1:0] count_q, count_d;
  logic         tc_q, tc_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] lim_c;
  logic [W-1:0] load_c;

  assign lim_c  = clamp_digits(limit);
  assign load_c = clamp_digits(load_val);

  // count never holds a digit above 9 in BCD mode, so a plain unsigned
  // compare of the full word is the same as a decimal compare.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = (load_c > lim_c) ? lim_c : load_c;
    end else if (en) begin
      if (up) begin
        if (count_q >= lim_c) begin
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
          count_d = (SATURATE != 0) ? lim_c : '0;
        end else begin
          count_d = step_inc(count_q);
        end
      end else begin
        if (count_q == '0) begin
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
          count_d = (SATURATE != 0) ? '0 : lim_c;
        end else if (count_q > lim_c) begin
          // limit was lowered under the count: snap down, not a boundary
          count_d = lim_c;
        end else begin
          count_d = step_dec(count_q);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_param_updown_counter
//   Three counter instances share clock and reset:
//     0: DIGITS=2, binary, wrap
//     1: DIGITS=2, BCD,    wrap
//     2: DIGITS=1, binary, saturate
//   Directed scenarios use one instance each. The random phase drives all three
//   and compares against a model that keeps the count as an integer in 0..limit.
// -----------------------------------------------------------------------------
module tb_param_updown_counter;

  logic       clock = 1'b0;
  logic       resetN;
  logic [2:0] clr, en, up, ld;
  logic [7:0] lv  [3];
  logic [7:0] lim [3];
  logic [7:0] cnt0, cnt1;
  logic [3:0] cnt2;
  logic [2:0] tc, ovf;

  int errors = 0;
  int checks = 0;

  int cfg_dig [3] = '{2, 2, 1};
  int cfg_bcd [3] = '{0, 1, 0};
  int cfg_sat [3] = '{0, 0, 1};

  always #5 clock = ~clock;

  param_updown_counter #(.DIGITS(2), .BCD(0), .SATURATE(0)) u_bin (
    .clock(clock), .resetN(resetN), .clr(clr[0]), .en(en[0]), .up(up[0]),
    .load(ld[0]), .load_val(lv[0]), .limit(lim[0]),
    .count(cnt0), .tc(tc[0]), .ovf(ovf[0]));

  param_updown_counter #(.DIGITS(2), .BCD(1), .SATURATE(0)) u_bcd (
    .clock(clock), .resetN(resetN), .clr(clr[1]), .en(en[1]), .up(up[1]),
    .load(ld[1]), .load_val(lv[1]), .limit(lim[1]),
    .count(cnt1), .tc(tc[1]), .ovf(ovf[1]));

  param_updown_counter #(.DIGITS(1), .BCD(0), .SATURATE(1)) u_sat (
    .clock(clock), .resetN(resetN), .clr(clr[2]), .en(en[2]), .up(up[2]),
    .load(ld[2]), .load_val(lv[2][3:0]), .limit(lim[2][3:0]),
    .count(cnt2), .tc(tc[2]), .ovf(ovf[2]));

  function automatic logic [7:0] get_cnt(input int i);
    case (i)
      0:       return cnt0;
      1:       return cnt1;
      default: return {4'h0, cnt2};
    endcase
  endfunction

  // Value of a register word as an integer (BCD digits above 9 read as 9).
  function automatic int dec_val(input logic [7:0] x, input int i);
    int v = 0;
    int p = 1;
    int d;
    for (int k = 0; k < cfg_dig[i]; k++) begin
      d = int'((x >> (4*k)) & 8'h0F);
      if (cfg_bcd[i] != 0) begin
        if (d > 9) d = 9;
        v += d * p;
        p *= 10;
      end else begin
        v += d * p;
        p *= 16;
      end
    end
    return v;
  endfunction

  // Integer back to the register encoding (hex or BCD digits).
  function automatic logic [7:0] enc_val(input int v, input int i);
    logic [7:0] r = 8'h00;
    int         rem = v;
    int         d;
    int         base;
    base = (cfg_bcd[i] != 0) ? 10 : 16;
    for (int k = 0; k < cfg_dig[i]; k++) begin
      d   = rem % base;
      rem = rem / base;
      r   = r | 8'(d << (4*k));
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    clr = '0; en = '0; up = '0; ld = '0;
    for (int i = 0; i < 3; i++) begin
      lv[i]  = 8'h00;
      lim[i] = 8'h00;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_cnt(i) !== 8'h00 || tc[i] !== 1'b0 || ovf[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: count=%h tc=%b ovf=%b, want 00/0/0", i, get_cnt(i), tc[i], ovf[i]);
      end
    end
    @(negedge clock);
    resetN = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_cnt(i) !== 8'h00 || tc[i] !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset[%0d]: count=%h tc=%b, want 00/0", i, get_cnt(i), tc[i]);
      end
    end
  endtask

  task automatic test_wrap_binary();
    int exp_c [7] = '{1, 2, 3, 4, 5, 0, 1};
    lim[0] = 8'h05;
    en[0]  = 1'b1;
    up[0]  = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++;
      if (cnt0 !== 8'(exp_c[k])) begin
        errors++;
        $display("FAIL wrap_count edge %0d: got %h want %h", k + 1, cnt0, 8'(exp_c[k]));
      end
      checks++;
      if (tc[0] !== (k == 5)) begin
        errors++;
        $display("FAIL wrap_tc edge %0d: got %b want %b", k + 1, tc[0], (k == 5));
      end
      checks++;
      if (ovf[0] !== (k >= 5)) begin
        errors++;
        $display("FAIL wrap_ovf edge %0d: got %b want %b", k + 1, ovf[0], (k >= 5));
      end
    end
    en[0] = 1'b0;
  endtask

  task automatic test_bcd();
    lim[1] = 8'h99;
    lv[1]  = 8'h09;
    ld[1]  = 1'b1;
    tick();
    checks++;
    if (cnt1 !== 8'h09) begin errors++; $display("FAIL bcd_load: got %h want 09", cnt1); end
    ld[1] = 1'b0; en[1] = 1'b1; up[1] = 1'b1;
    tick();
    checks++;
    if (cnt1 !== 8'h10) begin errors++; $display("FAIL bcd_carry: got %h want 10", cnt1); end
    tick();
    checks++;
    if (cnt1 !== 8'h11) begin errors++; $display("FAIL bcd_inc: got %h want 11", cnt1); end
    // borrow across a digit
    en[1] = 1'b0; ld[1] = 1'b1; lv[1] = 8'h10;
    tick();
    ld[1] = 1'b0; en[1] = 1'b1; up[1] = 1'b0;
    tick();
    checks++;
    if (cnt1 !== 8'h09) begin errors++; $display("FAIL bcd_borrow: got %h want 09", cnt1); end
    // down from 00 wraps to limit
    en[1] = 1'b0; clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0; en[1] = 1'b1; up[1] = 1'b0;
    tick();
    checks++;
    if (cnt1 !== 8'h99 || tc[1] !== 1'b1 || ovf[1] !== 1'b1) begin
      errors++;
      $display("FAIL bcd_underflow: count=%h tc=%b ovf=%b, want 99/1/1", cnt1, tc[1], ovf[1]);
    end
    tick();
    checks++;
    if (cnt1 !== 8'h98 || tc[1] !== 1'b0) begin
      errors++;
      $display("FAIL bcd_after_underflow: count=%h tc=%b, want 98/0", cnt1, tc[1]);
    end
    // load value with a non-decimal digit is clamped
    en[1] = 1'b0; ld[1] = 1'b1; lv[1] = 8'h3C;
    tick();
    checks++;
    if (cnt1 !== 8'h39) begin errors++; $display("FAIL bcd_clamp_load: got %h want 39", cnt1); end
    // limit dropped below count, counting up: boundary
    ld[1] = 1'b0; lim[1] = 8'h20; en[1] = 1'b1; up[1] = 1'b1;
    tick();
    checks++;
    if (cnt1 !== 8'h00 || tc[1] !== 1'b1) begin
      errors++;
      $display("FAIL bcd_limit_drop_up: count=%h tc=%b, want 00/1", cnt1, tc[1]);
    end
    // same with counting down: snaps to limit, no boundary
    en[1] = 1'b0; lim[1] = 8'h99; ld[1] = 1'b1;
    tick();
    ld[1] = 1'b0; lim[1] = 8'h20; en[1] = 1'b1; up[1] = 1'b0;
    tick();
    checks++;
    if (cnt1 !== 8'h20 || tc[1] !== 1'b0) begin
      errors++;
      $display("FAIL bcd_limit_drop_down: count=%h tc=%b, want 20/0", cnt1, tc[1]);
    end
    en[1] = 1'b0;
  endtask

  task automatic test_saturate();
    lim[2] = 8'h0A;
    lv[2]  = 8'h0A;
    ld[2]  = 1'b1;
    tick();
    checks++;
    if (cnt2 !== 4'hA) begin errors++; $display("FAIL sat_load: got %h want A", cnt2); end
    ld[2] = 1'b0; en[2] = 1'b1; up[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (cnt2 !== 4'hA || tc[2] !== 1'b1 || ovf[2] !== 1'b1) begin
        errors++;
        $display("FAIL sat_top edge %0d: count=%h tc=%b ovf=%b, want A/1/1", k + 1, cnt2, tc[2], ovf[2]);
      end
    end
    en[2] = 1'b0; clr[2] = 1'b1;
    tick();
    checks++;
    if (cnt2 !== 4'h0 || ovf[2] !== 1'b0 || tc[2] !== 1'b0) begin
      errors++;
      $display("FAIL sat_clr: count=%h tc=%b ovf=%b, want 0/0/0", cnt2, tc[2], ovf[2]);
    end
    clr[2] = 1'b0; en[2] = 1'b1; up[2] = 1'b0;
    tick();
    checks++;
    if (cnt2 !== 4'h0 || tc[2] !== 1'b1 || ovf[2] !== 1'b1) begin
      errors++;
      $display("FAIL sat_bottom: count=%h tc=%b ovf=%b, want 0/1/1", cnt2, tc[2], ovf[2]);
    end
    en[2] = 1'b0;
  endtask

  task automatic test_priority_and_zero_limit();
    clr[2] = 1'b1;
    tick();
    clr[2] = 1'b0;
    lim[2] = 8'h00; en[2] = 1'b1; up[2] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (cnt2 !== 4'h0 || tc[2] !== 1'b1 || ovf[2] !== 1'b1) begin
        errors++;
        $display("FAIL zero_limit edge %0d: count=%h tc=%b ovf=%b, want 0/1/1", k + 1, cnt2, tc[2], ovf[2]);
      end
    end
    en[2] = 1'b0;
    tick();
    checks++;
    if (tc[2] !== 1'b0) begin errors++; $display("FAIL tc_drop: got %b want 0", tc[2]); end
    lim[2] = 8'h07; lv[2] = 8'h03; ld[2] = 1'b1;
    tick();
    checks++;
    if (cnt2 !== 4'h3 || ovf[2] !== 1'b1 || tc[2] !== 1'b0) begin
      errors++;
      $display("FAIL load_keeps_ovf: count=%h tc=%b ovf=%b, want 3/0/1", cnt2, tc[2], ovf[2]);
    end
    clr[2] = 1'b1; en[2] = 1'b1; lv[2] = 8'h05;
    tick();
    checks++;
    if (cnt2 !== 4'h0 || ovf[2] !== 1'b0) begin
      errors++;
      $display("FAIL clr_priority: count=%h ovf=%b, want 0/0", cnt2, ovf[2]);
    end
    clr[2] = 1'b0; lv[2] = 8'h0F;
    tick();
    checks++;
    if (cnt2 !== 4'h7 || tc[2] !== 1'b0) begin
      errors++;
      $display("FAIL load_over_en_clamped: count=%h tc=%b, want 7/0", cnt2, tc[2]);
    end
    ld[2] = 1'b0; en[2] = 1'b0;
  endtask

  task automatic test_async_reset();
    lim[0] = 8'hFF; lv[0] = 8'h42; ld[0] = 1'b1;
    tick();
    checks++;
    if (cnt0 !== 8'h42) begin errors++; $display("FAIL ar_load: got %h want 42", cnt0); end
    ld[0] = 1'b0; en[0] = 1'b1; up[0] = 1'b1;
    tick();
    checks++;
    if (cnt0 !== 8'h43 || ovf[0] !== 1'b1) begin
      errors++;
      $display("FAIL ar_count: count=%h ovf=%b, want 43/1", cnt0, ovf[0]);
    end
    #2;
    resetN = 1'b0;
    #1;
    checks++;
    if (cnt0 !== 8'h00 || tc[0] !== 1'b0 || ovf[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%h tc=%b ovf=%b, want 00/0/0", cnt0, tc[0], ovf[0]);
    end
    #1;
    resetN = 1'b1;
    tick();
    checks++;
    if (cnt0 !== 8'h01 || tc[0] !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_edge: count=%h tc=%b, want 01/0", cnt0, tc[0]);
    end
    en[0] = 1'b0;
  endtask

  task automatic test_random();
    int   m_c   [3];
    logic m_tc  [3];
    logic m_ovf [3];
    int   L, V;
    logic [7:0] exp_c;
    clr = '0; en = '0; up = '0; ld = '0;
    for (int i = 0; i < 3; i++) begin
      lim[i]   = 8'($urandom);
      lv[i]    = 8'h00;
      m_c[i]   = 0;
      m_tc[i]  = 1'b0;
      m_ovf[i] = 1'b0;
    end
    @(negedge clock);
    resetN = 1'b0;
    #2;
    resetN = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        clr[i] = ($urandom_range(0, 31) == 0);
        ld[i]  = ($urandom_range(0, 9) == 0);
        en[i]  = ($urandom_range(0, 3) != 0);
        up[i]  = (cyc < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        lv[i]  = 8'($urandom);
        if ($urandom_range(0, 15) == 0) lim[i] = 8'($urandom);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        L = dec_val(lim[i], i);
        m_tc[i] = 1'b0;
        if (clr[i]) begin
          m_c[i]   = 0;
          m_ovf[i] = 1'b0;
        end else if (ld[i]) begin
          V      = dec_val(lv[i], i);
          m_c[i] = (V < L) ? V : L;
        end else if (en[i]) begin
          if (up[i]) begin
            if (m_c[i] >= L) begin
              m_tc[i] = 1'b1; m_ovf[i] = 1'b1;
              m_c[i]  = (cfg_sat[i] != 0) ? L : 0;
            end else begin
              m_c[i] = m_c[i] + 1;
            end
          end else begin
            if (m_c[i] == 0) begin
              m_tc[i] = 1'b1; m_ovf[i] = 1'b1;
              m_c[i]  = (cfg_sat[i] != 0) ? 0 : L;
            end else if (m_c[i] > L) begin
              m_c[i] = L;
            end else begin
              m_c[i] = m_c[i] - 1;
            end
          end
        end
        exp_c = enc_val(m_c[i], i);
        checks++;
        if (get_cnt(i) !== exp_c || tc[i] !== m_tc[i] || ovf[i] !== m_ovf[i]) begin
          errors++;
          $display("FAIL rand[%0d] cyc %0d: count=%h tc=%b ovf=%b, want %h/%b/%b",
                   i, cyc, get_cnt(i), tc[i], ovf[i], exp_c, m_tc[i], m_ovf[i]);
        end
      end
    end
    clr = '0; en = '0; ld = '0;
  endtask

  initial begin
    test_reset();
    test_wrap_binary();
    test_bcd();
    test_saturate();
    test_priority_and_zero_limit();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
